// File: rtl/i2c_wr_scheduler.sv
// i2c_wr_scheduler
// Shares one byte-level I2C write master between NUM_REQ requesters.
// Queued write bursts are granted round-robin. For each grant the device
// address, start register and byte count are latched for the master, and the
// granted requester's data bytes are streamed through to it. Completion, NACK
// and timeout are reported back to the owner, and a bus-idle gap is enforced
// before the next grant.
//
// Timing of one transaction:
//   cycle N     IDLE sees req_valid; selects the owner and latches its fields
//   cycle N+1   START: m_start and req_grant are high
//   N+2 ...     BUSY: bytes are popped on m_byte_ready
//   m_done at D req_done/req_err pulse at D+1, the first GAP cycle
// The timeout timer counts cycles from the m_start cycle, which is cycle 0.
// If m_done has not arrived by the cycle in which the timer would reach
// TIMEOUT, the master is aborted. m_abort and req_done then pulse exactly
// TIMEOUT cycles after m_start. An m_done in that same cycle takes priority.

module i2c_wr_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 10,
    parameter int TIMEOUT    = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_dev,
    input  logic [8*NUM_REQ-1:0] req_reg,
    input  logic [5*NUM_REQ-1:0] req_len,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_grant,
    output logic [NUM_REQ-1:0]   req_data_pop,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 req_err,
    output logic                 m_start,
    output logic [6:0]           m_dev,
    output logic [7:0]           m_reg,
    output logic [4:0]           m_len,
    output logic [7:0]           m_byte,
    input  logic                 m_byte_ready,
    input  logic                 m_done,
    input  logic                 m_nack,
    output logic                 m_abort
);

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam int CW = $clog2(GAP_CYCLES + 1) + 1;

    // Last timer value at which the transaction may still finish normally.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    // Last gap count. A zero-length gap still spends one cycle in GAP.
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_rrPtr;
    logic [IW-1:0]      r_gIdx;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_mStart;
    logic               r_mAbort;
    logic [NUM_REQ-1:0] r_reqDone;
    logic               r_reqErr;
    logic [6:0]         r_mDev;
    logic [7:0]         r_mReg;
    logic [4:0]         r_mLen;
    logic [4:0]         r_bytesLeft;
    logic [TW-1:0]      r_timer;
    logic [CW-1:0]      r_gapCnt;

    int                 w_scanIdx;
    logic               w_found;
    logic [IW-1:0]      w_pick;
    logic [IW-1:0]      w_nextPtr;
    logic [6:0]         w_selDev;
    logic [7:0]         w_selReg;
    logic [4:0]         w_selLen;
    logic               w_popFire;

    // Round-robin pick: the first pending requester at or above the pointer, with wrap.
    always_comb begin
        w_scanIdx = 0;
        w_found   = 1'b0;
        w_pick    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scanIdx = (int'(r_rrPtr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_scanIdx]) begin
                w_found = 1'b1;
                w_pick  = IW'(w_scanIdx);
            end
        end
    end

    assign w_selDev  = req_dev[7*int'(w_pick) +: 7];
    assign w_selReg  = req_reg[8*int'(w_pick) +: 8];
    assign w_selLen  = req_len[5*int'(w_pick) +: 5];
    assign w_nextPtr = IW'((int'(r_gIdx) + 1) % NUM_REQ);

    // A byte is consumed only while bytes remain; extra ready strobes are ignored.
    assign w_popFire    = (r_state == BUSY) && m_byte_ready && (r_bytesLeft != 5'd0);
    assign req_data_pop = w_popFire ? r_grant : '0;
    assign m_byte       = (|r_grant) ? req_data[8*int'(r_gIdx) +: 8] : 8'h00;

    assign req_grant = r_grant;
    assign req_done  = r_reqDone;
    assign req_err   = r_reqErr;
    assign m_start   = r_mStart;
    assign m_abort   = r_mAbort;
    assign m_dev     = r_mDev;
    assign m_reg     = r_mReg;
    assign m_len     = r_mLen;

    // Transaction FSM: grant, launch, stream/timeout supervision, idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rrPtr     <= '0;
            r_gIdx      <= '0;
            r_grant     <= '0;
            r_mStart    <= 1'b0;
            r_mAbort    <= 1'b0;
            r_reqDone   <= '0;
            r_reqErr    <= 1'b0;
            r_mDev      <= '0;
            r_mReg      <= '0;
            r_mLen      <= '0;
            r_bytesLeft <= '0;
            r_timer     <= '0;
            r_gapCnt    <= '0;
        end else begin
            r_mStart  <= 1'b0;
            r_mAbort  <= 1'b0;
            r_reqDone <= '0;
            r_reqErr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gIdx   <= w_pick;
                        r_grant  <= NUM_REQ'(1) << w_pick;
                        r_mDev   <= w_selDev;
                        r_mReg   <= w_selReg;
                        r_mLen   <= w_selLen;
                        r_mStart <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_bytesLeft <= r_mLen;
                    r_timer     <= r_timer + 1'b1;
                    r_state     <= BUSY;
                end
                BUSY: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_popFire) begin
                        r_bytesLeft <= r_bytesLeft - 5'd1;
                    end
                    if (m_done) begin
                        r_reqDone <= r_grant;
                        r_reqErr  <= m_nack;
                        r_grant   <= '0;
                        r_rrPtr   <= w_nextPtr;
                        r_gapCnt  <= '0;
                        r_state   <= GAP;
                    end else if (r_timer >= TIMER_LAST) begin
                        r_mAbort  <= 1'b1;
                        r_reqDone <= r_grant;
                        r_reqErr  <= 1'b1;
                        r_grant   <= '0;
                        r_rrPtr   <= w_nextPtr;
                        r_gapCnt  <= '0;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (r_gapCnt >= GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_wr_scheduler.sv
// Directed testbench for i2c_wr_scheduler (NUM_REQ=2, GAP_CYCLES=3, TIMEOUT=16).
// The bench plays both the requesters and the I2C master. Expected values are
// hand-derived from the transaction timing:
//   req_valid set at cycle N      -> m_start/grant at N+1
//   m_done at D                   -> req_done/req_err at D+1
//   with a request pending        -> next m_start at D+GAP+2
//   no m_done after m_start at S  -> m_abort/req_done at S+16
module tb_i2c_wr_scheduler;

    localparam int NREQ = 2;
    localparam int GAP  = 3;
    localparam int TOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [7*NREQ-1:0] req_dev;
    logic [8*NREQ-1:0] req_reg;
    logic [5*NREQ-1:0] req_len;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_grant;
    logic [NREQ-1:0]   req_data_pop;
    logic [NREQ-1:0]   req_done;
    logic              req_err;
    logic              m_start;
    logic [6:0]        m_dev;
    logic [7:0]        m_reg;
    logic [4:0]        m_len;
    logic [7:0]        m_byte;
    logic              m_byte_ready;
    logic              m_done;
    logic              m_nack;
    logic              m_abort;

    int checks = 0;
    int errors = 0;

    i2c_wr_scheduler #(
        .NUM_REQ   (NREQ),
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_dev     (req_dev),
        .req_reg     (req_reg),
        .req_len     (req_len),
        .req_data    (req_data),
        .req_grant   (req_grant),
        .req_data_pop(req_data_pop),
        .req_done    (req_done),
        .req_err     (req_err),
        .m_start     (m_start),
        .m_dev       (m_dev),
        .m_reg       (m_reg),
        .m_len       (m_len),
        .m_byte      (m_byte),
        .m_byte_ready(m_byte_ready),
        .m_done      (m_done),
        .m_nack      (m_nack),
        .m_abort     (m_abort)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready,
                                 input logic done, input logic nack);
        req_valid    = valid;
        m_byte_ready = ready;
        m_done       = done;
        m_nack       = nack;
    endtask

    task automatic setReq(input int g, input logic [6:0] dev, input logic [7:0] rg, input logic [4:0] len);
        req_dev[7*g +: 7] = dev;
        req_reg[8*g +: 8] = rg;
        req_len[5*g +: 5] = len;
    endtask

    // Wait for a launch (bounded), check the latched fields, pop nPops bytes,
    // then complete with m_done/nack and check the completion pulse.
    task automatic runTxn(input int g, input logic [6:0] dev, input logic [7:0] rg,
                          input int len, input int nPops, input logic nack, input logic dropValid);
        logic [7:0] base;
        base = (g == 0) ? 8'hAA : 8'h10;
        req_data[8*g +: 8] = base;
        for (int c = 0; c < 40 && m_start !== 1'b1; c++) stepCycle();
        checkOutput("start_seen", 32'(m_start), 32'd1);
        checkOutput("grant", 32'(req_grant), 32'(1 << g));
        checkOutput("m_dev", 32'(m_dev), 32'(dev));
        checkOutput("m_reg", 32'(m_reg), 32'(rg));
        checkOutput("m_len", 32'(m_len), 32'(len));
        if (dropValid) req_valid = '0;
        stepCycle();
        checkOutput("start_one_cycle", 32'(m_start), 32'd0);
        checkOutput("grant_held", 32'(req_grant), 32'(1 << g));
        for (int i = 0; i < nPops; i++) begin
            m_byte_ready = 1'b1;
            #1;
            checkOutput("pop", 32'(req_data_pop), 32'(1 << g));
            checkOutput("m_byte", 32'(m_byte), 32'(base + 8'(i * 17)));
            stepCycle();
            req_data[8*g +: 8] = base + 8'((i + 1) * 17);
        end
        if (nPops == len) begin
            m_byte_ready = 1'b1;
            #1;
            checkOutput("no_extra_pop", 32'(req_data_pop), 32'd0);
        end
        m_byte_ready = 1'b0;
        m_done       = 1'b1;
        m_nack       = nack;
        #1;
        checkOutput("done_not_early", 32'(req_done), 32'd0);
        stepCycle();
        m_done = 1'b0;
        m_nack = 1'b0;
        checkOutput("req_done", 32'(req_done), 32'(1 << g));
        checkOutput("req_err", 32'(req_err), 32'(nack));
        checkOutput("grant_released", 32'(req_grant), 32'd0);
        checkOutput("no_abort", 32'(m_abort), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req_dev  = '0;
        req_reg  = '0;
        req_len  = '0;
        req_data = '0;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();

        // Reset state
        checkOutput("rst_grant", 32'(req_grant), 32'd0);
        checkOutput("rst_pop", 32'(req_data_pop), 32'd0);
        checkOutput("rst_done", 32'(req_done), 32'd0);
        checkOutput("rst_err", 32'(req_err), 32'd0);
        checkOutput("rst_start", 32'(m_start), 32'd0);
        checkOutput("rst_abort", 32'(m_abort), 32'd0);
        checkOutput("rst_fields", {9'd0, m_dev, m_reg, m_len, 3'd0}, 32'd0);
        checkOutput("rst_byte", 32'(m_byte), 32'd0);
        rst_n = 1'b1;
        stepCycle();

        // Single request: req0 dev 0x0A reg 18 len 3, data AA/BB/CC
        $display("[TB] single request");
        setReq(0, 7'h0A, 8'd18, 5'd3);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("start_latency", 32'(m_start), 32'd1);
        runTxn(0, 7'h0A, 8'd18, 3, 3, 1'b0, 1'b0);

        // req0 stays valid: no grant in the gap, relaunch at D+GAP+2
        for (int k = 0; k < GAP; k++) begin
            stepCycle();
            checkOutput("gap_no_grant", 32'(req_grant), 32'd0);
            checkOutput("gap_no_start", 32'(m_start), 32'd0);
        end
        stepCycle();
        checkOutput("gap_then_start", 32'(m_start), 32'd1);

        // NACK after one byte
        $display("[TB] nack");
        runTxn(0, 7'h0A, 8'd18, 3, 1, 1'b1, 1'b0);

        // Fairness with both pending; the pointer now favours req1.
        // req1 first with len 0 (address-only), later with len 2.
        $display("[TB] fairness");
        setReq(1, 7'h21, 8'h40, 5'd0);
        req_valid = 2'b11;
        runTxn(1, 7'h21, 8'h40, 0, 0, 1'b0, 1'b0);
        req_len[9:5] = 5'd2;
        runTxn(0, 7'h0A, 8'd18, 3, 3, 1'b0, 1'b0);
        runTxn(1, 7'h21, 8'h40, 2, 2, 1'b0, 1'b0);
        // req_valid dropped right after the grant; the burst still completes
        runTxn(0, 7'h0A, 8'd18, 3, 3, 1'b0, 1'b1);

        // Timeout: no m_done, abort 16 cycles after m_start
        $display("[TB] timeout");
        req_valid = 2'b01;
        for (int c = 0; c < 40 && m_start !== 1'b1; c++) stepCycle();
        checkOutput("to_start_seen", 32'(m_start), 32'd1);
        checkOutput("to_grant", 32'(req_grant), 32'd1);
        req_valid = 2'b00;
        for (int c = 0; c < TOUT - 1; c++) stepCycle();
        checkOutput("to_no_abort_early", 32'(m_abort), 32'd0);
        checkOutput("to_no_done_early", 32'(req_done), 32'd0);
        stepCycle();
        checkOutput("to_abort", 32'(m_abort), 32'd1);
        checkOutput("to_done", 32'(req_done), 32'd1);
        checkOutput("to_err", 32'(req_err), 32'd1);
        checkOutput("to_grant_released", 32'(req_grant), 32'd0);
        stepCycle();
        checkOutput("to_abort_pulse", 32'(m_abort), 32'd0);

        // m_done in the cycle the timer would reach TIMEOUT: m_done wins
        $display("[TB] timeout tie");
        req_valid = 2'b01;
        for (int c = 0; c < 40 && m_start !== 1'b1; c++) stepCycle();
        checkOutput("tie_start_seen", 32'(m_start), 32'd1);
        req_valid = 2'b00;
        for (int c = 0; c < TOUT - 1; c++) stepCycle();
        m_done = 1'b1;
        m_nack = 1'b0;
        stepCycle();
        m_done = 1'b0;
        checkOutput("tie_no_abort", 32'(m_abort), 32'd0);
        checkOutput("tie_done", 32'(req_done), 32'd1);
        checkOutput("tie_err", 32'(req_err), 32'd0);

        // m_done outside BUSY is ignored
        m_done = 1'b1;
        m_nack = 1'b1;
        stepCycle();
        m_done = 1'b0;
        m_nack = 1'b0;
        checkOutput("stray_done", 32'(req_done), 32'd0);
        checkOutput("stray_err", 32'(req_err), 32'd0);
        for (int c = 0; c < 5; c++) stepCycle();
        checkOutput("idle_no_grant", 32'(req_grant), 32'd0);
        checkOutput("idle_no_start", 32'(m_start), 32'd0);

        // Async reset in the middle of a burst
        $display("[TB] reset mid-busy");
        req_valid = 2'b01;
        for (int c = 0; c < 40 && m_start !== 1'b1; c++) stepCycle();
        checkOutput("mr_start_seen", 32'(m_start), 32'd1);
        stepCycle();
        m_byte_ready = 1'b1;
        #1;
        checkOutput("mr_pop_before", 32'(req_data_pop), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_grant", 32'(req_grant), 32'd0);
        checkOutput("mr_pop", 32'(req_data_pop), 32'd0);
        checkOutput("mr_done", 32'(req_done), 32'd0);
        checkOutput("mr_abort", 32'(m_abort), 32'd0);
        checkOutput("mr_dev", 32'(m_dev), 32'd0);
        checkOutput("mr_byte", 32'(m_byte), 32'd0);
        m_byte_ready = 1'b0;
        req_valid    = 2'b11;
        stepCycle();
        checkOutput("mr_held_grant", 32'(req_grant), 32'd0);
        rst_n = 1'b1;
        // The pointer restarts at 0, so req0 wins with both pending
        runTxn(0, 7'h0A, 8'd18, 3, 3, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the end, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
